// File: rtl/speck_pkg.sv
// rtl/speck_pkg.sv - SPECK-128/128 constants, step state encoding and rotation helpers
package speck_pkg;

    localparam int WORD_W = 64;
    localparam int ALPHA  = 8;
    localparam int BETA   = 3;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LOAD    = 4'd1;
    localparam logic [3:0] ST_COMPUTE = 4'd2;
    localparam logic [3:0] ST_DONE    = 4'd3;

    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_COMPUTE = ST_COMPUTE,
        S_DONE    = ST_DONE
    } step_state_e;

    // Rotations on one SPECK word; a zero amount degenerates to the identity.
    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int sh);
        return (v >> sh) | (v << (WORD_W - sh));
    endfunction

    function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int sh);
        return (v << sh) | (v >> (WORD_W - sh));
    endfunction

endpackage

// File: rtl/speck_step_fsm.sv
// rtl/speck_step_fsm.sv - IDLE/LOAD/COMPUTE/DONE start/finished controller for one step engine
module speck_step_fsm
    import speck_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       capture,
    output logic       compute,
    output logic       finished,
    output logic [3:0] state_code
);

    step_state_e state, state_next;

    // State register; reset wins over any start request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and strobes; start is only honoured in IDLE and DONE.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        compute    = 1'b0;
        finished   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                compute    = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                finished = 1'b1;
                if (start) begin
                    capture    = 1'b1;
                    state_next = S_LOAD;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign state_code = state;

endmodule

// File: rtl/speck_round_decrypt.sv
// rtl/speck_round_decrypt.sv - SPECK-128 key-step and decrypt-round engines (SPECK_ENC_EN adds encrypt mode)
module speck_round_decrypt
    import speck_pkg::ror, speck_pkg::rol;
#(
    parameter int WORD_W = speck_pkg::WORD_W,
    parameter int ALPHA  = speck_pkg::ALPHA,
    parameter int BETA   = speck_pkg::BETA,
    parameter int CTR_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ks_start,
    input  logic [2*WORD_W-1:0]   ks_key,
    input  logic [CTR_W-1:0]      ks_round_ctr,
    output logic [2*WORD_W-1:0]   ks_out_key,
    output logic                  ks_finished,
    output logic [3:0]            ks_state,
    input  logic                  rd_start,
    input  logic [WORD_W-1:0]     rd_subkey,
    input  logic [2*WORD_W-1:0]   rd_ciphertext,
`ifdef SPECK_ENC_EN
    input  logic                  rd_encrypt,
`endif
    output logic [2*WORD_W-1:0]   rd_plaintext,
    output logic                  rd_finished,
    output logic [3:0]            rd_state
);

    logic ks_capture, ks_compute;
    logic rd_capture, rd_compute;

    logic [WORD_W-1:0]   ks_k_q, ks_l_q, ks_ctr_q;
    logic [WORD_W-1:0]   ks_k_next, ks_l_next;
    logic [2*WORD_W-1:0] ks_out_q;

    logic [WORD_W-1:0]   rd_x_q, rd_y_q, rd_key_q;
    logic [WORD_W-1:0]   rd_x_next, rd_y_next;
    logic [2*WORD_W-1:0] rd_out_q;

    speck_step_fsm u_ks_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (ks_start),
        .capture    (ks_capture),
        .compute    (ks_compute),
        .finished   (ks_finished),
        .state_code (ks_state)
    );

    speck_step_fsm u_rd_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (rd_start),
        .capture    (rd_capture),
        .compute    (rd_compute),
        .finished   (rd_finished),
        .state_code (rd_state)
    );

    // Key expansion step: only the low word of the round index enters the XOR.
    always_comb begin
        ks_l_next = (ror(ks_l_q, ALPHA) + ks_k_q) ^ ks_ctr_q;
        ks_k_next = rol(ks_k_q, BETA) ^ ks_l_next;
    end

    // Key-step datapath: capture on accepted start, result written once in COMPUTE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ks_k_q   <= '0;
            ks_l_q   <= '0;
            ks_ctr_q <= '0;
            ks_out_q <= '0;
        end else begin
            if (ks_capture) begin
                ks_k_q   <= ks_key[2*WORD_W-1:WORD_W];
                ks_l_q   <= ks_key[WORD_W-1:0];
                ks_ctr_q <= WORD_W'(ks_round_ctr);
            end
            if (ks_compute) begin
                ks_out_q <= {ks_k_next, ks_l_next};
            end
        end
    end

`ifdef SPECK_ENC_EN
    logic rd_enc_q;
    logic [WORD_W-1:0] enc_x, enc_y, dec_x, dec_y;

    // Both round directions are built; the mode latched with start picks one.
    always_comb begin
        dec_y     = ror(rd_x_q ^ rd_y_q, BETA);
        dec_x     = rol((rd_x_q ^ rd_key_q) - dec_y, ALPHA);
        enc_x     = (ror(rd_x_q, ALPHA) + rd_y_q) ^ rd_key_q;
        enc_y     = rol(rd_y_q, BETA) ^ enc_x;
        rd_x_next = rd_enc_q ? enc_x : dec_x;
        rd_y_next = rd_enc_q ? enc_y : dec_y;
    end

    // Mode flag is captured alongside the block and round key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_enc_q <= 1'b0;
        end else if (rd_capture) begin
            rd_enc_q <= rd_encrypt;
        end
    end
`else
    // Inverse round: undo the y update first, then recover x from it.
    always_comb begin
        rd_y_next = ror(rd_x_q ^ rd_y_q, BETA);
        rd_x_next = rol((rd_x_q ^ rd_key_q) - rd_y_next, ALPHA);
    end
`endif

    // Round datapath: capture on accepted start, result written once in COMPUTE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_x_q   <= '0;
            rd_y_q   <= '0;
            rd_key_q <= '0;
            rd_out_q <= '0;
        end else begin
            if (rd_capture) begin
                rd_x_q   <= rd_ciphertext[2*WORD_W-1:WORD_W];
                rd_y_q   <= rd_ciphertext[WORD_W-1:0];
                rd_key_q <= rd_subkey;
            end
            if (rd_compute) begin
                rd_out_q <= {rd_x_next, rd_y_next};
            end
        end
    end

    assign ks_out_key   = ks_out_q;
    assign rd_plaintext = rd_out_q;

endmodule

// File: tb/tb_speck_round_decrypt.sv
// tb/tb_speck_round_decrypt.sv - scoreboard bench for speck_round_decrypt
module tb_speck_round_decrypt;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ks_start = 1'b0;
    logic [127:0] ks_key = '0;
    logic [63:0]  ks_round_ctr = '0;
    logic [127:0] ks_out_key;
    logic         ks_finished;
    logic [3:0]   ks_state;
    logic         rd_start = 1'b0;
    logic [63:0]  rd_subkey = '0;
    logic [127:0] rd_ciphertext = '0;
`ifdef SPECK_ENC_EN
    logic         rd_encrypt = 1'b0;
`endif
    logic [127:0] rd_plaintext;
    logic         rd_finished;
    logic [3:0]   rd_state;

    int n_checks = 0;
    int n_fail = 0;

    logic [127:0] ks_exp_q[$];
    logic [127:0] rd_exp_q[$];
    logic ks_fin_prev = 1'b0;
    logic rd_fin_prev = 1'b0;

    logic [63:0]  rk[0:32];
    logic [127:0] st[0:32];

    speck_round_decrypt dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ks_start      (ks_start),
        .ks_key        (ks_key),
        .ks_round_ctr  (ks_round_ctr),
        .ks_out_key    (ks_out_key),
        .ks_finished   (ks_finished),
        .ks_state      (ks_state),
        .rd_start      (rd_start),
        .rd_subkey     (rd_subkey),
        .rd_ciphertext (rd_ciphertext),
`ifdef SPECK_ENC_EN
        .rd_encrypt    (rd_encrypt),
`endif
        .rd_plaintext  (rd_plaintext),
        .rd_finished   (rd_finished),
        .rd_state      (rd_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] m_ror(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    function automatic logic [63:0] m_rol(input logic [63:0] v, input int s);
        return (v << s) | (v >> (64 - s));
    endfunction

    function automatic logic [127:0] m_key_step(input logic [127:0] key, input logic [63:0] i);
        logic [63:0] l2, k2;
        l2 = (m_ror(key[63:0], 8) + key[127:64]) ^ i;
        k2 = m_rol(key[127:64], 3) ^ l2;
        return {k2, l2};
    endfunction

    function automatic logic [127:0] m_encrypt(input logic [127:0] blk, input logic [63:0] k);
        logic [63:0] x2, y2;
        x2 = (m_ror(blk[127:64], 8) + blk[63:0]) ^ k;
        y2 = m_rol(blk[63:0], 3) ^ x2;
        return {x2, y2};
    endfunction

    // Scoreboard monitor: each new finished pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n && ks_finished && !ks_fin_prev) begin
            if (ks_exp_q.size() == 0) check("ks_unexpected_result", 1, 0);
            else check("ks_out_key", ks_out_key, ks_exp_q.pop_front());
        end
        if (rst_n && rd_finished && !rd_fin_prev) begin
            if (rd_exp_q.size() == 0) check("rd_unexpected_result", 1, 0);
            else check("rd_plaintext", rd_plaintext, rd_exp_q.pop_front());
        end
        ks_fin_prev <= ks_finished;
        rd_fin_prev <= rd_finished;
    end

    task automatic ks_step(input logic [127:0] key, input logic [63:0] ctr,
                           input logic [127:0] exp, output logic [127:0] res, output int lat);
        @(negedge clk);
        ks_key = key;
        ks_round_ctr = ctr;
        ks_start = 1'b1;
        ks_exp_q.push_back(exp);
        @(negedge clk);
        ks_start = 1'b0;
        ks_key = ~key;
        ks_round_ctr = ~ctr;
        lat = 1;
        while (!ks_finished && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!ks_finished) check("ks_timeout", 0, 1);
        res = ks_out_key;
    endtask

    task automatic rd_step(input logic [127:0] blk, input logic [63:0] key,
                           input logic [127:0] exp, output logic [127:0] res, output int lat);
        @(negedge clk);
        rd_ciphertext = blk;
        rd_subkey = key;
        rd_start = 1'b1;
        rd_exp_q.push_back(exp);
        @(negedge clk);
        rd_start = 1'b0;
        rd_ciphertext = ~blk;
        rd_subkey = ~key;
        lat = 1;
        while (!rd_finished && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rd_finished) check("rd_timeout", 0, 1);
        res = rd_plaintext;
    endtask

    initial begin
        logic [127:0] r1, r2, cur;
        logic [127:0] ks_m;
        int lat1, lat2;
        logic seen_fin;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ks_finished", ks_finished, 0);
        check("reset_rd_finished", rd_finished, 0);
        check("reset_ks_state", ks_state, 0);
        check("reset_rd_state", rd_state, 0);
        check("reset_ks_out_key", ks_out_key, 0);
        check("reset_rd_plaintext", rd_plaintext, 0);
        rst_n = 1'b1;

        // Directed key step with latency and hold checks
        ks_step({64'h1, 64'h0}, 64'd0, {64'h9, 64'h1}, r1, lat1);
        check("ks_latency", lat1, 3);
        repeat (3) @(negedge clk);
        check("ks_hold_finished", ks_finished, 1);
        check("ks_hold_value", ks_out_key, {64'h9, 64'h1});
        check("ks_hold_state", ks_state, 4'd3);

        // Directed decrypt round
        rd_step({64'h0100000000000000, 64'h0100000000000000}, 64'h0,
                {64'h1, 64'h0}, r2, lat2);
        check("rd_latency", lat2, 3);

        // Both engines started on the same edge
        fork
            ks_step(128'h0, 64'd5, {64'h5, 64'h5}, r1, lat1);
            rd_step(128'h0, 64'h1, {64'h100, 64'h0}, r2, lat2);
        join
        check("ks_concurrent_latency", lat1, 3);
        check("rd_concurrent_latency", lat2, 3);

        // Start during COMPUTE is ignored
        @(negedge clk);
        rd_ciphertext = {64'h0100000000000000, 64'h0100000000000000};
        rd_subkey = 64'h0;
        rd_start = 1'b1;
        rd_exp_q.push_back({64'h1, 64'h0});
        @(negedge clk);
        rd_start = 1'b0;
        check("rd_state_load", rd_state, 4'd1);
        @(negedge clk);
        check("rd_state_compute", rd_state, 4'd2);
        rd_ciphertext = 128'h0;
        rd_subkey = 64'h1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("rd_state_done", rd_state, 4'd3);
        check("rd_finished_after_ignore", rd_finished, 1);
        repeat (3) @(negedge clk);
        check("rd_state_still_done", rd_state, 4'd3);
        check("rd_ignore_queue_empty", rd_exp_q.size(), 0);

        // Reset during LOAD
        @(negedge clk);
        rd_ciphertext = 128'h0;
        rd_subkey = 64'h1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("rd_state_load_pre_reset", rd_state, 4'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rd_state_after_reset", rd_state, 4'd0);
        check("rd_finished_after_reset", rd_finished, 0);
        check("rd_plaintext_after_reset", rd_plaintext, 0);
        check("ks_out_key_after_reset", ks_out_key, 0);
        rst_n = 1'b1;
        seen_fin = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rd_finished) seen_fin = 1'b1;
        end
        check("rd_finished_never_after_reset", seen_fin, 0);
        check("rd_state_idle_after_reset", rd_state, 4'd0);

        // 32 key steps then 32 reverse decrypt rounds, chained through the DUT
        ks_m = {64'h0706050403020100, 64'h0f0e0d0c0b0a0908};
        rk[0] = ks_m[127:64];
        cur = ks_m;
        for (int i = 0; i < 32; i++) begin
            ks_m = m_key_step(ks_m, 64'(i));
            rk[i+1] = ks_m[127:64];
            ks_step(cur, 64'(i), ks_m, r1, lat1);
            cur = r1;
        end
        st[0] = {64'h6c61766975716520, 64'h7469206564616d20};
        for (int r = 0; r < 32; r++) st[r+1] = m_encrypt(st[r], rk[r]);
        cur = st[32];
        for (int j = 0; j < 32; j++) begin
            rd_step(cur, rk[31-j], st[31-j], r2, lat2);
            cur = r2;
        end
        check("chain_plaintext", cur, {64'h6c61766975716520, 64'h7469206564616d20});

        repeat (2) @(negedge clk);
        check("ks_queue_drained", ks_exp_q.size(), 0);
        check("rd_queue_drained", rd_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
